// File: rtl/clock_gen_multi.sv
// Multi-channel programmable clock divider off the 5 kHz system clock.
// Each channel can run on its own or be cascaded from the registered Tick of the channel below it.
module clock_gen_multi #(
    parameter int N_CH  = 2,
    parameter int CNT_W = 16,
    parameter int DIV0  = 5,
    parameter int DIVN  = 5000
) (
    input  logic              Clock_5K,
    input  logic              Reset,
    input  logic [N_CH-1:0]   En,
    input  logic [N_CH-1:0]   Mode,
    input  logic [N_CH-1:0]   Casc,
    input  logic              Sync_Clr,
    input  logic              Load,
    input  logic [2:0]        Load_Ch,
    input  logic [CNT_W-1:0]  Load_Div,
    output logic [N_CH-1:0]   Clk_Out,
    output logic [N_CH-1:0]   Tick
);

    localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

    for (genvar k = 0; k < N_CH; k++) begin : g_ch
        localparam logic [2:0]       CH_IDX  = 3'(k);
        localparam logic [CNT_W-1:0] DIV_RST = (k == 0) ? CNT_W'(DIV0) : CNT_W'(DIVN);

        logic [CNT_W-1:0] div_r;
        logic [CNT_W-1:0] cnt_r;
        logic             tick_r;
        logic             clk_r;
        logic             casc_ok;
        logic             load_hit;
        logic             adv;
        logic             at_end;
        logic [CNT_W-1:0] cnt_nxt;

        if (k == 0) begin : g_first
            // Channel 0 has no upstream channel, so its Casc bit never gates it.
            assign casc_ok = !Casc[0] || 1'b1;
        end else begin : g_casc
            assign casc_ok = !Casc[k] || Tick[k-1];
        end

        assign load_hit = Load && (Load_Ch == CH_IDX);
        assign adv      = En[k] && casc_ok && (div_r != '0);
        // Only consulted when adv is set, so div_r is at least 1 here.
        assign at_end   = (cnt_r == div_r - ONE);
        assign cnt_nxt  = at_end ? '0 : cnt_r + ONE;

        always_ff @(posedge Clock_5K or negedge Reset) begin
            if (!Reset) begin
                div_r  <= DIV_RST;
                cnt_r  <= '0;
                tick_r <= 1'b0;
                clk_r  <= 1'b0;
            end else begin
                if (load_hit) begin
                    div_r <= Load_Div;
                end
                if (Sync_Clr || load_hit || div_r == '0) begin
                    cnt_r  <= '0;
                    tick_r <= 1'b0;
                    clk_r  <= 1'b0;
                end else if (!En[k]) begin
                    tick_r <= 1'b0;
                end else if (adv) begin
                    cnt_r  <= cnt_nxt;
                    tick_r <= at_end;
                    clk_r  <= Mode[k] ? at_end : (cnt_nxt >= (div_r >> 1));
                end else begin
                    // Enabled but waiting on the upstream tick.
                    tick_r <= 1'b0;
                    clk_r  <= Mode[k] ? 1'b0 : (cnt_r >= (div_r >> 1));
                end
            end
        end

        assign Tick[k]    = tick_r;
        assign Clk_Out[k] = clk_r;
    end

endmodule
